// File: rtl/read_return_reorder.sv
// Read return reorder buffer: round-robin collects tagged bank returns into
// index-addressed slots and retires them to the RNIC strictly in index order.
module read_return_reorder #(
  parameter int DATA_WIDTH = 16,
  parameter int IDX_W      = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [15:0]             bank_valid,
  input  logic [16*DATA_WIDTH-1:0] bank_data,
  input  logic [16*IDX_W-1:0]     bank_index,
  output logic [15:0]             bank_ack_o,
  input  logic                    rnic_busy,
  output logic                    out_valid_o,
  output logic [DATA_WIDTH-1:0]   out_data_o,
  output logic [IDX_W-1:0]        out_index_o,
  output logic                    read_retire_o,
  output logic                    err_o
);
  localparam int DEPTH = 1 << IDX_W;

  // Handshakes: a bank return transfers when bank_valid[i] && bank_ack_o[i];
  // an output word transfers when out_valid_o && !rnic_busy, and while
  // rnic_busy is high a presented word holds stable.

  logic [3:0]            rr_ptr;
  logic [3:0]            grant_idx;
  logic [3:0]            cand;
  logic                  grant_any;
  logic [IDX_W-1:0]      head;
  logic [IDX_W-1:0]      acc_idx;
  logic [DATA_WIDTH-1:0] acc_data;
  logic [DATA_WIDTH-1:0] slot [DEPTH];
  logic [DEPTH-1:0]      vld;
  logic [DEPTH-1:0]      vld_nxt;
  logic                  acc_write;
  logic                  acc_collide;
  logic                  out_free;
  logic                  retire;

  // First requesting bank at or after rr_ptr, wrapping modulo 16.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = rr_ptr;
    cand      = rr_ptr;
    for (int i = 0; i < 16; i++) begin
      cand = rr_ptr + 4'(i);
      if (!grant_any && bank_valid[cand]) begin
        grant_any = 1'b1;
        grant_idx = cand;
      end
    end
  end

  assign bank_ack_o  = (grant_any && !rst) ? (16'b1 << grant_idx) : 16'b0;
  assign acc_idx     = bank_index[int'(grant_idx)*IDX_W +: IDX_W];
  assign acc_data    = bank_data[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
  assign acc_write   = grant_any && !vld[acc_idx];
  assign acc_collide = grant_any && vld[acc_idx];

  assign out_free      = !out_valid_o || !rnic_busy;
  assign retire        = vld[head] && out_free;
  assign read_retire_o = out_valid_o && !rnic_busy && !rst;

  // A return to the head slot cannot coincide with its retirement: a write
  // needs vld=0 while retirement needs vld=1.
  always_comb begin
    vld_nxt = vld;
    if (retire)    vld_nxt[head]    = 1'b0;
    if (acc_write) vld_nxt[acc_idx] = 1'b1;
  end

  // Slot data needs no reset; it is only observed behind its vld bit.
  always_ff @(posedge clk) begin
    if (acc_write) slot[acc_idx] <= acc_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr      <= '0;
      head        <= '0;
      vld         <= '0;
      out_valid_o <= 1'b0;
      out_data_o  <= '0;
      out_index_o <= '0;
      err_o       <= 1'b0;
    end else begin
      vld <= vld_nxt;
      if (grant_any)   rr_ptr <= grant_idx + 4'd1;
      if (acc_collide) err_o  <= 1'b1;
      if (out_free) begin
        out_valid_o <= vld[head];
        if (vld[head]) begin
          out_data_o  <= slot[head];
          out_index_o <= head;
          head        <= head + IDX_W'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_read_return_reorder.sv
// Bench for read_return_reorder: directed scenarios plus randomized traffic,
// checked by a scoreboard fed from a round-robin/reorder reference model.
module tb_read_return_reorder;
  localparam int DW = 16;
  localparam int IW = 4;
  localparam int NB = 16;
  localparam int DEPTH = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [NB-1:0]    bank_valid = '0;
  logic [NB*DW-1:0] bank_data = '0;
  logic [NB*IW-1:0] bank_index = '0;
  logic [NB-1:0]    bank_ack_o;
  logic             rnic_busy = 1'b0;
  logic             out_valid_o;
  logic [DW-1:0]    out_data_o;
  logic [IW-1:0]    out_index_o;
  logic             read_retire_o;
  logic             err_o;

  read_return_reorder #(.DATA_WIDTH(DW), .IDX_W(IW)) dut (
    .clk(clk), .rst(rst), .bank_valid(bank_valid), .bank_data(bank_data),
    .bank_index(bank_index), .bank_ack_o(bank_ack_o), .rnic_busy(rnic_busy),
    .out_valid_o(out_valid_o), .out_data_o(out_data_o), .out_index_o(out_index_o),
    .read_retire_o(read_retire_o), .err_o(err_o)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int failures = 0;
  logic [IW+DW-1:0] exp_q[$];
  int delivered = 0;

  // ---------------- reference model ----------------
  int            m_rr = 0;
  bit            m_have[DEPTH];
  logic [DW-1:0] m_mem[DEPTH];
  int            m_next = 0;
  bit            m_err = 0;
  int            last_g = -1;
  int            gen = 0;
  int            deliv_base = 0;
  int            pool[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic begin_cycle();
    @(negedge clk);
    if (last_g >= 0) bank_valid[last_g] = 1'b0;
    last_g = -1;
  endtask

  task automatic present(input int b, input int idx, input logic [DW-1:0] d);
    bank_valid[b] = 1'b1;
    bank_index[b*IW +: IW] = idx[IW-1:0];
    bank_data[b*DW +: DW] = d;
  endtask

  // Checks the state left by the last edge, then advances the model by the
  // acceptance the coming edge will perform.
  task automatic end_cycle();
    int g;
    int b;
    int k;
    logic [NB-1:0] exp_ack;
    #1;
    chk("err_o", err_o, m_err);
    g = -1;
    if (!rst) begin
      for (int i = 0; i < NB; i++) begin
        b = (m_rr + i) % NB;
        if (g < 0 && bank_valid[b]) g = b;
      end
    end
    exp_ack = (g < 0) ? '0 : (NB'(1) << g);
    chk("bank_ack_o", bank_ack_o, exp_ack);
    if (rst) begin
      m_rr = 0; m_next = 0; m_err = 0; last_g = -1;
      for (int i = 0; i < DEPTH; i++) m_have[i] = 0;
      pool.delete();
      gen = 0;
      deliv_base = delivered;
    end else if (g >= 0) begin
      k = int'(bank_index[g*IW +: IW]);
      if (m_have[k]) m_err = 1;
      else begin
        m_have[k] = 1;
        m_mem[k] = bank_data[g*DW +: DW];
      end
      while (m_have[m_next]) begin
        exp_q.push_back({IW'(m_next), m_mem[m_next]});
        m_have[m_next] = 0;
        m_next = (m_next + 1) % DEPTH;
      end
      m_rr = (g + 1) % NB;
      last_g = g;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      begin_cycle();
      end_cycle();
    end
  endtask

  task automatic do_reset();
    begin_cycle();
    rst = 1'b1;
    rnic_busy = 1'b0;
    end_cycle();
    begin_cycle();
    rst = 1'b0;
    bank_valid = '0;
    end_cycle();
    chk("rst_out_valid", out_valid_o, 0);
    chk("rst_out_data", out_data_o, 0);
    chk("rst_out_index", out_index_o, 0);
    chk("rst_read_retire", read_retire_o, 0);
  endtask

  task automatic expect_out(input string name, input int idx, input logic [DW-1:0] d);
    chk({name, "_valid"}, out_valid_o, 1);
    chk({name, "_index"}, out_index_o, idx % DEPTH);
    chk({name, "_data"}, out_data_o, d);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    #2;
    if (rst) begin
      exp_q.delete();
    end else if (out_valid_o) begin
      if (exp_q.size() == 0) begin
        chk("out_unexpected", out_valid_o, 0);
      end else begin
        chk("out_index_data", {out_index_o, out_data_o}, exp_q[0]);
        if (!rnic_busy) begin
          chk("read_retire_o", read_retire_o, 1);
          void'(exp_q.pop_front());
          delivered++;
        end else begin
          chk("read_retire_stall", read_retire_o, 0);
        end
      end
    end else begin
      chk("read_retire_idle", read_retire_o, 0);
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int h;
    int k;
    int s;
    int j;
    bit found;
    logic [DW-1:0] dd[20];

    do_reset();

    // In-order single return, latency two cycles after acceptance.
    begin_cycle(); present(3, 0, 16'h00AA); end_cycle();
    chk("t1_ack", bank_ack_o, 16'h0008);
    idle(1);
    chk("t1_not_early", out_valid_o, 0);
    idle(1);
    expect_out("t1_out", 0, 16'h00AA);
    chk("t1_retire", read_retire_o, 1);

    // Reorder: h+2, h+1, h arrive; delivered h, h+1, h+2 back to back.
    h = m_next;
    for (int i = 0; i < 7; i++) begin
      begin_cycle();
      if (i == 0) present(1, (h + 2) % DEPTH, 16'h2222);
      if (i == 1) present(2, (h + 1) % DEPTH, 16'h1111);
      if (i == 2) present(4, h, 16'h0000);
      end_cycle();
      if (i == 4) expect_out("ro0", h, 16'h0000);
      if (i == 5) expect_out("ro1", h + 1, 16'h1111);
      if (i == 6) expect_out("ro2", h + 2, 16'h2222);
    end
    idle(2);

    // Round-robin among banks 0, 5, 15 from rr_ptr=0; bank 0 re-presents.
    do_reset();
    begin_cycle();
    present(0, 0, 16'h0A00); present(5, 1, 16'h0A05); present(15, 2, 16'h0A0F);
    end_cycle();
    chk("rr_first", bank_ack_o, 16'h0001);
    begin_cycle(); end_cycle();
    chk("rr_second", bank_ack_o, 16'h0020);
    begin_cycle(); present(0, 3, 16'h0B00); end_cycle();
    chk("rr_third", bank_ack_o, 16'h8000);
    begin_cycle(); end_cycle();
    chk("rr_wrap", bank_ack_o, 16'h0001);
    idle(6);

    // Backpressure: index 0 held for 4 cycles with index 1 buffered.
    do_reset();
    begin_cycle(); present(2, 0, 16'hB0B0); end_cycle();
    begin_cycle(); present(7, 1, 16'hB1B1); end_cycle();
    for (int i = 0; i < 4; i++) begin
      begin_cycle(); rnic_busy = 1'b1; end_cycle();
      expect_out("bp_hold", 0, 16'hB0B0);
      chk("bp_no_retire", read_retire_o, 0);
    end
    begin_cycle(); rnic_busy = 1'b0; end_cycle();
    expect_out("bp_release", 0, 16'hB0B0);
    chk("bp_release_retire", read_retire_o, 1);
    begin_cycle(); end_cycle();
    expect_out("bp_next", 1, 16'hB1B1);
    idle(2);

    // Wrap: 20 in-order returns, one retirement per cycle across 15 -> 0.
    do_reset();
    for (int i = 0; i < 20; i++) dd[i] = DW'($urandom);
    for (int i = 0; i < 22; i++) begin
      begin_cycle();
      if (i < 20) present(i % NB, i % DEPTH, dd[i]);
      end_cycle();
      if (i >= 2) expect_out("wrap", i - 2, dd[i-2]);
    end

    // Collision: index k returned twice before it can retire.
    h = m_next;
    k = (h + 3) % DEPTH;
    begin_cycle(); present(1, k, 16'hC0DE); end_cycle();
    begin_cycle(); present(2, k, 16'hDEAD); end_cycle();
    begin_cycle(); end_cycle();
    chk("coll_err", err_o, 1);
    found = 0;
    for (int i = 0; i < 12; i++) begin
      begin_cycle();
      if (i < 3) present(3 + i, (h + i) % DEPTH, DW'($urandom));
      end_cycle();
      if (out_valid_o && out_index_o == IW'(k)) begin
        found = 1;
        chk("coll_first_data", out_data_o, 16'hC0DE);
      end
    end
    chk("coll_delivered", found, 1);

    // Reset mid-stream with output held and three entries buffered.
    h = m_next;
    for (int i = 0; i < 6; i++) begin
      begin_cycle();
      rnic_busy = 1'b1;
      if (i < 4) present(6 + i, (h + i) % DEPTH, DW'($urandom));
      end_cycle();
    end
    chk("mid_held_valid", out_valid_o, 1);
    do_reset();
    begin_cycle(); present(11, 0, 16'h5A5A); end_cycle();
    idle(1);
    chk("post_rst_not_early", out_valid_o, 0);
    idle(1);
    expect_out("post_rst", 0, 16'h5A5A);
    idle(2);

    // Randomized traffic: out-of-order tags within a 16-deep credit window.
    do_reset();
    for (int c = 0; c < 800; c++) begin
      begin_cycle();
      while (gen < delivered - deliv_base + DEPTH) begin
        pool.push_back(gen);
        gen++;
      end
      for (int b = 0; b < NB; b++) begin
        if (!bank_valid[b] && pool.size() > 0 && $urandom_range(0, 2) == 0) begin
          j = $urandom_range(0, pool.size() - 1);
          s = pool[j];
          pool.delete(j);
          present(b, s % DEPTH, DW'($urandom));
        end
      end
      rnic_busy = ($urandom_range(0, 3) == 0);
      end_cycle();
    end
    for (int c = 0; c < 400; c++) begin
      if (pool.size() == 0 && bank_valid == '0 && exp_q.size() == 0) break;
      begin_cycle();
      rnic_busy = 1'b0;
      for (int b = 0; b < NB; b++) begin
        if (!bank_valid[b] && pool.size() > 0) begin
          s = pool.pop_front();
          present(b, s % DEPTH, DW'($urandom));
        end
      end
      end_cycle();
    end
    chk("drain_empty", exp_q.size(), 0);
    chk("drain_banks", bank_valid, 0);
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "simulation time limit");
  end
endmodule
